// File: rtl/pending_priority_encoder.sv
// ---------------------------------------------------------------------------
// pending_priority_encoder
//
// Captures N request lines into a sticky pending register and offers one
// winning index at a time on a registered valid/ready port. A pending bit is
// cleared only when its index is accepted. An offered index is never
// preempted: while valid is high and ready is low, out and valid are frozen.
//
// Optional build macro:
//   PPE_ROUND_ROBIN_EN  - defined:   round-robin selection starting at rr_ptr
//                         undefined: fixed priority, highest index wins
//
// Ports:
//   clk      in   1      clock, rising edge
//   rst      in   1      synchronous active-high reset
//   in       in   N      request lines, sampled every cycle
//   ready    in   1      consumer accepts the offered index this cycle
//   valid    out  1      out holds a pending index
//   out      out  IDX_W  offered index (registered)
//   pending  out  N      current pending register
//   ovf      out  1      one-cycle pulse: a request hit an already-pending bit
// ---------------------------------------------------------------------------
module pending_priority_encoder #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  input  logic             ready,
  output logic             valid,
  output logic [IDX_W-1:0] out,
  output logic [N-1:0]     pending,
  output logic             ovf
);

  logic             acc;
  logic [N-1:0]     clr;
  logic [N-1:0]     pend_nx;
  logic             ovf_nx;
  logic [IDX_W-1:0] sel_idx;

  // Successor index with wrap-around at N-1 (N need not be a power of two).
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] o);
    next_idx = (o == IDX_W'(N - 1)) ? '0 : o + 1'b1;
  endfunction

`ifdef PPE_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_base;

  // Search upward from base with wrap; the first set bit wins. Iterating
  // from the farthest offset down lets the nearest hit overwrite the result.
  function automatic logic [IDX_W-1:0] sel_rr(input logic [N-1:0]     p,
                                              input logic [IDX_W-1:0] base);
    int j;
    sel_rr = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(base) + k) % N;
      if (p[j]) sel_rr = IDX_W'(j);
    end
  endfunction
`else
  // Fixed priority: the highest set index wins (later iterations overwrite).
  function automatic logic [IDX_W-1:0] sel_fixed(input logic [N-1:0] p);
    sel_fixed = '0;
    for (int i = 0; i < N; i++) begin
      if (p[i]) sel_fixed = IDX_W'(i);
    end
  endfunction
`endif

  always_comb begin
    acc = valid & ready;
    clr = '0;
    if (acc) clr[out] = 1'b1;
    // Set wins over clear: a request arriving on the index being accepted
    // keeps that bit pending.
    pend_nx = (pending & ~clr) | in;
    ovf_nx  = |(in & pending & ~clr);
`ifdef PPE_ROUND_ROBIN_EN
    // On an accept the search starts just past the granted index, so the
    // index reloaded in the same cycle already respects the new pointer.
    rr_base = acc ? next_idx(out) : rr_ptr;
    sel_idx = sel_rr(pend_nx, rr_base);
`else
    sel_idx = sel_fixed(pend_nx);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      valid   <= 1'b0;
      out     <= '0;
      ovf     <= 1'b0;
`ifdef PPE_ROUND_ROBIN_EN
      rr_ptr  <= '0;
`endif
    end else begin
      pending <= pend_nx;
      ovf     <= ovf_nx;
      // Output stage reloads only when empty or when the offer is taken;
      // otherwise the offered index is held regardless of new requests.
      if (!valid || acc) begin
        valid <= |pend_nx;
        if (|pend_nx) out <= sel_idx;
      end
`ifdef PPE_ROUND_ROBIN_EN
      if (acc) rr_ptr <= next_idx(out);
`endif
    end
  end

endmodule

// File: tb/tb_pending_priority_encoder.sv
// ---------------------------------------------------------------------------
// tb_pending_priority_encoder
//
// Scoreboard bench: the driver applies one set of inputs per cycle and pushes
// the expected post-edge state (from a behavioural model of the request set
// and the currently offered index) into a queue; an independent monitor pops
// one entry after every rising edge and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_pending_priority_encoder;

  localparam int N     = 8;
  localparam int IDX_W = $clog2(N);

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     in;
  logic             ready;
  logic             valid;
  logic [IDX_W-1:0] out;
  logic [N-1:0]     pending;
  logic             ovf;

  typedef struct {
    logic             valid;
    logic [IDX_W-1:0] out;
    logic [N-1:0]     pending;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural model state
  bit   m_pend[N];
  bit   m_valid;
  int   m_out;
  bit   m_ovf;
  int   m_rr;

  pending_priority_encoder #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .ready   (ready),
    .valid   (valid),
    .out     (out),
    .pending (pending),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int pick();
    int w = -1;
`ifdef PPE_ROUND_ROBIN_EN
    for (int k = 0; k < N && w < 0; k++)
      if (m_pend[(m_rr + k) % N]) w = (m_rr + k) % N;
`else
    for (int i = N - 1; i >= 0 && w < 0; i--)
      if (m_pend[i]) w = i;
`endif
    return w;
  endfunction

  // Advance the model by one clock edge with the given inputs and push the
  // resulting expected outputs.
  task automatic model_step(input bit r, input logic [N-1:0] req, input bit rdy);
    exp_t e;
    bit   taken;
    int   w;
    if (r) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_valid = 0; m_out = 0; m_ovf = 0; m_rr = 0;
    end else begin
      taken = m_valid && rdy;
      if (taken) begin
        m_pend[m_out] = 0;
        m_rr = (m_out + 1) % N;
      end
      m_ovf = 0;
      for (int i = 0; i < N; i++) begin
        if (req[i] && m_pend[i]) m_ovf = 1;
        if (req[i]) m_pend[i] = 1;
      end
      if (!m_valid || taken) begin
        w = pick();
        m_valid = (w >= 0);
        if (w >= 0) m_out = w;
      end
    end
    e.valid = m_valid;
    e.out   = IDX_W'(m_out);
    e.ovf   = m_ovf;
    for (int i = 0; i < N; i++) e.pending[i] = m_pend[i];
    exp_q.push_back(e);
  endtask

  task automatic step(input bit r, input logic [N-1:0] req, input bit rdy);
    @(negedge clk);
    rst   = r;
    in    = req;
    ready = rdy;
    model_step(r, req, rdy);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: one expected entry per rising edge after stimulus starts.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("valid",   32'(valid),   32'(e.valid));
      check("out",     32'(out),     32'(e.out));
      check("pending", 32'(pending), 32'(e.pending));
      check("ovf",     32'(ovf),     32'(e.ovf));
    end
  end

  initial begin
    rst = 1'b1; in = '0; ready = 1'b0;
    foreach (m_pend[i]) m_pend[i] = 0;
    m_valid = 0; m_out = 0; m_ovf = 0; m_rr = 0;

    // Reset with requests and ready active; then release idle
    step(1, 8'hFF, 1);
    step(1, 8'hFF, 0);
    step(0, 8'h00, 0);
    step(0, 8'h00, 1);

    // Single request, accepted immediately
    step(0, 8'h20, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);

    // Multiple requests held, then drained back-to-back
    step(0, 8'h85, 0);
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);

    // Higher-priority request does not preempt an offered index
    step(0, 8'h04, 0);
    step(0, 8'h80, 0);
    step(0, 8'h00, 0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);

    // Overflow pulse, then set-wins on simultaneous accept and request
    step(0, 8'h08, 0);
    step(0, 8'h08, 0);
    step(0, 8'h00, 0);
    step(0, 8'h08, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);

    // Reset in the middle of an offer
    step(0, 8'h66, 0);
    step(1, 8'h11, 1);
    step(0, 8'h00, 1);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] req;
      req = N'($urandom) & N'($urandom) & N'($urandom);
      if ($urandom_range(0, 3) == 0) req = '0;
      step($urandom_range(0, 99) == 0, req, $urandom_range(0, 3) != 0);
    end

    // Drain
    for (int c = 0; c < N + 2; c++) step(0, 8'h00, 1);

    @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
